hwf_sv_scheduler: RTL and testbench

//  Sequences hwf_kernel over all support vectors (SVs) for one test image and accumulates the per-SV kernel outputs.
//  For each SV it generates test-pixel, SV-pixel and alpha ROM addresses, clears the kernel, and throttles it via stall_MEM.
//  It then waits out the kernel latency, captures hwf_out and adds it to the decision sum.

---
 rtl/hwf_sv_scheduler_if.sv | 38 +++
 rtl/hwf_sv_scheduler.sv | 142 ++++++++++++++
 tb/tb_hwf_sv_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hwf_sv_scheduler_if.sv
// rtl/hwf_sv_scheduler_if.sv - Control, ROM address and kernel signal bundle for hwf_sv_scheduler
interface hwf_sv_scheduler_if #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 4,
  parameter int NUM_OF_SV     = 87,
  parameter int ACC_W         = 24
);
  localparam int PA = ($clog2(NUM_OF_PIXELS) > 1) ? $clog2(NUM_OF_PIXELS) : 1;
  localparam int SA = ($clog2(NUM_OF_SV) > 1) ? $clog2(NUM_OF_SV) : 1;
  localparam int MA = $clog2(NUM_OF_SV * NUM_OF_PIXELS);

  logic                    start;
  logic                    pause;
  logic                    busy;
  logic                    done;
  logic                    mem_rd_en;
  logic [PA-1:0]           test_addr;
  logic [MA-1:0]           sv_addr;
  logic [SA-1:0]           alpha_addr;
  logic                    kern_clr;
  logic                    kern_stall_MEM;
  logic [2*XLEN_PIXEL-1:0] kern_out;
  logic                    result_valid;
  logic [SA-1:0]           sv_idx_out;
  logic [ACC_W-1:0]        acc_out;

  modport master (
    output start, pause, kern_out,
    input  busy, done, mem_rd_en, test_addr, sv_addr, alpha_addr,
           kern_clr, kern_stall_MEM, result_valid, sv_idx_out, acc_out
  );

  modport slave (
    input  start, pause, kern_out,
    output busy, done, mem_rd_en, test_addr, sv_addr, alpha_addr,
           kern_clr, kern_stall_MEM, result_valid, sv_idx_out, acc_out
  );
endinterface

// File: rtl/hwf_sv_scheduler.sv
// rtl/hwf_sv_scheduler.sv - Sequences hwf_kernel over all support vectors and accumulates the decision sum
module hwf_sv_scheduler #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 4,
  parameter int NUM_OF_SV     = 87,
  parameter int KERNEL_LAT    = 2,
  parameter int ACC_W         = 24
) (
  input logic               clk,
  input logic               rst,
  hwf_sv_scheduler_if.slave bus
);
  localparam int PA    = ($clog2(NUM_OF_PIXELS) > 1) ? $clog2(NUM_OF_PIXELS) : 1;
  localparam int SA    = ($clog2(NUM_OF_SV) > 1) ? $clog2(NUM_OF_SV) : 1;
  localparam int MA    = $clog2(NUM_OF_SV * NUM_OF_PIXELS);
  localparam int KW    = 2 * XLEN_PIXEL;
  localparam int SUM_W = ((ACC_W > KW) ? ACC_W : KW) + 1;
  localparam int WC_W  = ($clog2(KERNEL_LAT + 1) > 1) ? $clog2(KERNEL_LAT + 1) : 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACCUM, S_DONE} state_t;

  state_t           state;
  logic [PA-1:0]    pix_idx;
  logic [SA-1:0]    sv_idx;
  logic [MA-1:0]    sv_base;     // sv_idx * NUM_OF_PIXELS, stepped alongside sv_idx
  logic [WC_W-1:0]  wait_cnt;
  logic             busy_q;
  logic             done_q;
  logic             clr_q;
  logic             stall_q;
  logic             rv_q;
  logic [SA-1:0]    sv_out_q;
  logic [ACC_W-1:0] acc_q;
  logic             issue;
  logic [SUM_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_next;

  // A read goes out on every ISSUE cycle that memory is ready; pause gates it the same cycle
  assign issue = (state == S_ISSUE) && !bus.pause;

  assign bus.mem_rd_en      = issue;
  assign bus.test_addr      = pix_idx;
  assign bus.sv_addr        = sv_base + MA'(pix_idx);
  assign bus.alpha_addr     = sv_idx;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.kern_clr       = clr_q;
  assign bus.kern_stall_MEM = stall_q;
  assign bus.result_valid   = rv_q;
  assign bus.sv_idx_out     = sv_out_q;
  assign bus.acc_out        = acc_q;

  // Saturating add of the zero-extended kernel output; once at max it stays there
  always_comb begin
    acc_sum  = SUM_W'(acc_q) + SUM_W'(bus.kern_out);
    acc_next = (acc_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : acc_sum[ACC_W-1:0];
  end

  // Main sequencer: issue pixels per SV, wait out ROM + kernel latency, accumulate, repeat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pix_idx  <= '0;
      sv_idx   <= '0;
      sv_base  <= '0;
      wait_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clr_q    <= 1'b0;
      stall_q  <= 1'b1;
      rv_q     <= 1'b0;
      sv_out_q <= '0;
      acc_q    <= '0;
    end else begin
      clr_q <= 1'b0;
      rv_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          stall_q <= 1'b1;
          if (bus.start) begin
            state   <= S_ISSUE;
            pix_idx <= '0;
            sv_idx  <= '0;
            sv_base <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Kernel only advances on the cycle after a read, when ROM data is present
          stall_q <= !issue;
          if (issue) begin
            if (pix_idx == PA'(NUM_OF_PIXELS - 1)) begin
              pix_idx  <= '0;
              wait_cnt <= '0;
              state    <= S_WAIT;
            end else begin
              pix_idx <= pix_idx + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == WC_W'(KERNEL_LAT)) begin
            state    <= S_ACCUM;
            stall_q  <= 1'b1;
            acc_q    <= acc_next;
            rv_q     <= 1'b1;
            sv_out_q <= sv_idx;
          end else begin
            stall_q  <= 1'b0;
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          stall_q <= 1'b1;
          if (sv_idx == SA'(NUM_OF_SV - 1)) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            sv_idx  <= sv_idx + 1'b1;
            sv_base <= sv_base + MA'(NUM_OF_PIXELS);
            clr_q   <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_DONE: begin
          stall_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          stall_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hwf_sv_scheduler.sv
// tb/tb_hwf_sv_scheduler.sv - Directed scoreboard bench for hwf_sv_scheduler
module tb_hwf_sv_scheduler;
  localparam int NP  = 4;
  localparam int NSV = 87;

  typedef struct {
    int     sv;
    longint acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hwf_sv_scheduler_if #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV), .ACC_W(24)) bus ();
  hwf_sv_scheduler_if #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV), .ACC_W(16)) sbus ();

  hwf_sv_scheduler #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV), .KERNEL_LAT(2), .ACC_W(24))
    dut (.clk(clk), .rst(rst), .bus(bus));
  hwf_sv_scheduler #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV), .KERNEL_LAT(2), .ACC_W(16))
    dut_sat (.clk(clk), .rst(rst), .bus(sbus));

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   exp_sv = 0;
  int   exp_pix = 0;
  int   clr_cnt = 0;
  int   res_cnt = 0;
  int   sat_cnt = 0;
  int   lat;
  bit   found;
  exp_t sb_q[$];
  exp_t sat_q[$];
  exp_t e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: sample at negedge and check the issue stream and result scoreboards
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.pause) chk("no_read_while_paused", bus.mem_rd_en, 0);
    if (bus.mem_rd_en) begin
      chk("test_addr", bus.test_addr, exp_pix);
      chk("sv_addr", bus.sv_addr, exp_sv * NP + exp_pix);
      chk("alpha_addr", bus.alpha_addr, exp_sv);
      if (exp_pix == NP - 1) begin
        exp_pix = 0;
        exp_sv++;
      end else begin
        exp_pix++;
      end
    end
    if (bus.kern_clr) clr_cnt++;
    if (bus.result_valid) begin
      res_cnt++;
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sv_idx_out", bus.sv_idx_out, e.sv);
        chk("acc_out", bus.acc_out, e.acc);
      end
    end
    if (sbus.result_valid) begin
      sat_cnt++;
      chk("sat_sb_nonempty", sat_q.size() != 0, 1);
      if (sat_q.size() != 0) begin
        e = sat_q.pop_front();
        chk("sat_sv_idx_out", sbus.sv_idx_out, e.sv);
        chk("sat_acc_out", sbus.acc_out, e.acc);
      end
    end
  endtask

  task automatic push_main(input longint kval);
    longint s = 0;
    exp_t   x;
    for (int k = 0; k < NSV; k++) begin
      s = s + kval;
      if (s > 24'hFFFFFF) s = 24'hFFFFFF;
      x.sv = k;
      x.acc = s;
      sb_q.push_back(x);
    end
  endtask

  task automatic push_sat(input longint kval);
    longint s = 0;
    exp_t   x;
    for (int k = 0; k < NSV; k++) begin
      s = s + kval;
      if (s > 16'hFFFF) s = 16'hFFFF;
      x.sv = k;
      x.acc = s;
      sat_q.push_back(x);
    end
  endtask

  task automatic start_main();
    exp_sv = 0;
    exp_pix = 0;
    clr_cnt = 0;
    res_cnt = 0;
    bus.start = 1'b1;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input bit sat, output int l);
    l = -1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if ((sat ? sbus.done : bus.done) === 1'b1) begin
        l = cyc - t0;
        break;
      end
    end
  endtask

  task automatic wait_issue(input int sv, input int pix, output bit f);
    f = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (bus.mem_rd_en && bus.alpha_addr == sv && bus.test_addr == pix) begin
        f = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bus.start = 1'b1;
    bus.pause = 1'b0;
    bus.kern_out = 16'd100;
    sbus.start = 1'b0;
    sbus.pause = 1'b0;
    sbus.kern_out = 16'hFFFF;
    #2 rst = 1'b0;

    // T1: reset held with start high
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
    end
    chk("rst_stall", bus.kern_stall_MEM, 1);
    chk("rst_acc", bus.acc_out, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_kern_clr", bus.kern_clr, 0);
    chk("rst_sv_addr", bus.sv_addr, 0);
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("idle_busy", bus.busy, 0);

    // T2/T3: nominal run with kern_out = 100
    push_main(100);
    start_main();
    chk("first_clr", bus.kern_clr, 1);
    chk("first_busy", bus.busy, 1);
    chk("first_stall", bus.kern_stall_MEM, 1);
    tick();
    chk("stall_after_read", bus.kern_stall_MEM, 0);
    wait_done(1'b0, lat);
    chk("t2_done_latency", lat, 697);
    chk("t2_results", res_cnt, NSV);
    chk("t2_acc", bus.acc_out, 8700);
    chk("t2_busy_in_done", bus.busy, 0);
    chk("t3_clr_per_sv", clr_cnt, NSV);
    chk("t3_issue_count", exp_sv * NP + exp_pix, NSV * NP);
    chk("t2_sb_drained", sb_q.size(), 0);
    tick();
    chk("t2_done_pulse", bus.done, 0);
    chk("t2_acc_hold", bus.acc_out, 8700);

    // T4: pause for three cycles during SV 10
    push_main(100);
    start_main();
    wait_issue(10, 1, found);
    chk("t4_reach_sv10", found, 1);
    @(posedge clk);
    #1 bus.pause = 1'b1;
    tick();
    chk("t4_stall_p1", bus.kern_stall_MEM, 0);
    tick();
    chk("t4_stall_p2", bus.kern_stall_MEM, 1);
    tick();
    chk("t4_stall_p3", bus.kern_stall_MEM, 1);
    @(posedge clk);
    #1 bus.pause = 1'b0;
    wait_done(1'b0, lat);
    chk("t4_done_latency", lat, 700);
    chk("t4_acc", bus.acc_out, 8700);
    chk("t4_issue_count", exp_sv * NP + exp_pix, NSV * NP);

    // T5: saturation with a 16-bit accumulator
    push_sat(16'hFFFF);
    sat_cnt = 0;
    sbus.start = 1'b1;
    t0 = cyc;
    tick();
    sbus.start = 1'b0;
    wait_done(1'b1, lat);
    chk("t5_done_latency", lat, 697);
    chk("t5_acc", sbus.acc_out, 16'hFFFF);
    chk("t5_results", sat_cnt, NSV);

    // T6: abort during WAIT of SV 40, then restart
    push_main(100);
    start_main();
    wait_issue(40, NP - 1, found);
    chk("t6_reach_sv40", found, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_abort_busy", bus.busy, 0);
      chk("t6_abort_done", bus.done, 0);
    end
    chk("t6_abort_acc", bus.acc_out, 0);
    chk("t6_abort_results", res_cnt, 40);
    rst = 1'b1;
    tick();
    bus.kern_out = 16'd1;
    push_main(1);
    start_main();
    for (int i = 0; i < 50; i++) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(1'b0, lat);
    chk("t6_done_latency", lat, 697);
    chk("t6_acc", bus.acc_out, 87);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_restart", bus.busy, 0);
    end
    chk("t6_acc_hold", bus.acc_out, 87);
    chk("t6_results", res_cnt, NSV);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
